multiplier_32: RTL and testbench

MULTIPLIER_32 -- requirements
Module: multiplier_32

---
 rtl/multiplier_32.sv | 127 ++++++++++++
 tb/tb_multiplier_32.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_32.sv
// 32x32 radix-2 shift-add multiplier producing a registered 64-bit product.
// Define MULTIPLIER_32_SIGNED_EN for two's complement operands and product.
module full_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

module multiplier_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mout1,
    output logic [31:0] mout2,
    output logic        finished
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] la;
    logic [31:0] lb;
    logic [31:0] mcand;
    logic [63:0] acc;
    logic [5:0]  cnt;
    logic [31:0] amag;
    logic [31:0] bmag;
    logic [31:0] addend;
    logic [31:0] sum;
    logic        cout;
    logic [63:0] nxt;
    logic [63:0] prod;
    logic        chg;

`ifdef MULTIPLIER_32_SIGNED_EN
    logic neg;

    assign amag = a[31] ? (~a + 32'd1) : a;
    assign bmag = b[31] ? (~b + 32'd1) : b;
    assign prod = neg ? (~nxt + 64'd1) : nxt;
`else
    assign amag = a;
    assign bmag = b;
    assign prod = nxt;
`endif

    // Low word of acc doubles as the multiplier register; its LSB picks the add.
    assign addend = acc[0] ? mcand : 32'd0;
    assign nxt    = {cout, sum, acc[31:1]};
    assign chg    = (a != la) || (b != lb);

    full_adder_32 u_add (
        .a    (acc[63:32]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            la       <= '0;
            lb       <= '0;
            mcand    <= '0;
            acc      <= '0;
            cnt      <= '0;
            mout1    <= '0;
            mout2    <= '0;
            finished <= 1'b0;
`ifdef MULTIPLIER_32_SIGNED_EN
            neg      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    la    <= a;
                    lb    <= b;
                    mcand <= amag;
                    acc   <= {32'd0, bmag};
                    cnt   <= '0;
`ifdef MULTIPLIER_32_SIGNED_EN
                    neg   <= a[31] ^ b[31];
`endif
                    state <= BUSY;
                end
                BUSY: begin
                    acc <= nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        mout2    <= prod[63:32];
                        mout1    <= prod[31:0];
                        finished <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (chg) begin
                        la       <= a;
                        lb       <= b;
                        mcand    <= amag;
                        acc      <= {32'd0, bmag};
                        cnt      <= '0;
                        finished <= 1'b0;
`ifdef MULTIPLIER_32_SIGNED_EN
                        neg      <= a[31] ^ b[31];
`endif
                        state    <= BUSY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_32.sv
// Scoreboard bench for multiplier_32: latency, corners, re-trigger, reset abort.
// Expected products come from a bench-side model or fixed constants.
module tb_multiplier_32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] mout1;
    logic [31:0] mout2;
    logic        finished;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sbq[$];

    multiplier_32 dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .mout1    (mout1),
        .mout2    (mout2),
        .finished (finished)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef MULTIPLIER_32_SIGNED_EN
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        model = sx * sy;
`else
        model = {32'd0, x} * {32'd0, y};
`endif
    endfunction

    function automatic logic [63:0] pop_exp();
        if (sbq.size() == 0) return 64'hDEAD_BEEF_DEAD_BEEF;
        return sbq.pop_front();
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (finished !== 1'b1 && n < 40);
    endtask

    task automatic test_reset();
        int n;
        logic [63:0] e;
        reset = 1'b0;
        a = 32'd56;
        b = 32'd44;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (finished !== 1'b0) begin
            bad++;
            $display("FAIL reset_finished got=%b exp=0", finished);
        end
        total++;
        if ({mout2, mout1} !== 64'd0) begin
            bad++;
            $display("FAIL reset_mout got=%h exp=0", {mout2, mout1});
        end
        sbq.push_back(64'h0000_0000_0000_09A0);
        @(negedge clk);
        reset = 1'b1;
        wait_done(n);
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL basic_latency got=%0d exp=33", n);
        end
        e = pop_exp();
        total++;
        if ({mout2, mout1} !== e) begin
            bad++;
            $display("FAIL basic_56x44 got=%h exp=%h", {mout2, mout1}, e);
        end
    endtask

    task automatic test_change();
        int n;
        logic held;
        logic dropped;
        logic [63:0] e;
        held = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (finished !== 1'b1 || mout1 !== 32'h9A0) held = 1'b0;
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL done_hold got=%b/%h exp=1/9a0", finished, mout1);
        end
        sbq.push_back(model(32'd24, 32'd44));
        @(negedge clk);
        a = 32'd24;
        n = 0;
        held = 1'b1;
        dropped = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) dropped = (finished === 1'b0);
            if (finished === 1'b0 && mout1 !== 32'h9A0) held = 1'b0;
        end while (finished !== 1'b1 && n < 40);
        total++;
        if (dropped !== 1'b1) begin
            bad++;
            $display("FAIL change_drop got=%b exp=1", dropped);
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL busy_hold_mout1 got=0 exp=1");
        end
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL change_latency got=%0d exp=33", n);
        end
        e = pop_exp();
        total++;
        if ({mout2, mout1} !== e || mout1 !== 32'h420) begin
            bad++;
            $display("FAIL change_24x44 got=%h exp=%h", {mout2, mout1}, e);
        end
    endtask

    task automatic test_corners();
        logic [31:0] ta[3];
        logic [31:0] tb[3];
        logic [63:0] te[3];
        logic [63:0] e;
        int n;
        ta[0] = 32'hFFFF_FFFF;
        tb[0] = 32'hFFFF_FFFF;
        ta[1] = 32'd0;
        tb[1] = 32'h1234_5678;
        ta[2] = 32'd1;
        tb[2] = 32'h8000_0000;
`ifdef MULTIPLIER_32_SIGNED_EN
        te[0] = 64'h0000_0000_0000_0001;
        te[2] = 64'hFFFF_FFFF_8000_0000;
`else
        te[0] = 64'hFFFF_FFFE_0000_0001;
        te[2] = 64'h0000_0000_8000_0000;
`endif
        te[1] = 64'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = ta[i];
            b = tb[i];
            sbq.push_back(te[i]);
            wait_done(n);
            total++;
            if (n !== 33) begin
                bad++;
                $display("FAIL corner%0d_latency got=%0d exp=33", i, n);
            end
            e = pop_exp();
            total++;
            if ({mout2, mout1} !== e) begin
                bad++;
                $display("FAIL corner%0d got=%h exp=%h", i, {mout2, mout1}, e);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        logic [63:0] e;
        @(negedge clk);
        a = 32'd7;
        b = 32'd9;
        sbq.push_back(model(32'd7, 32'd9));
        sbq.push_back(model(32'd100, 32'd9));
        repeat (5) @(posedge clk);
        @(negedge clk);
        a = 32'd100;
        wait_done(n);
        total++;
        if (n !== 28) begin
            bad++;
            $display("FAIL ignore_latency got=%0d exp=28", n);
        end
        e = pop_exp();
        total++;
        if ({mout2, mout1} !== e) begin
            bad++;
            $display("FAIL ignore_7x9 got=%h exp=%h", {mout2, mout1}, e);
        end
        wait_done(n);
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL relatch_latency got=%0d exp=33", n);
        end
        e = pop_exp();
        total++;
        if ({mout2, mout1} !== e) begin
            bad++;
            $display("FAIL relatch_100x9 got=%h exp=%h", {mout2, mout1}, e);
        end
    endtask

    task automatic test_midreset();
        int n;
        logic [63:0] e;
        @(negedge clk);
        a = 32'h0001_2345;
        b = 32'h000A_BCDE;
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (finished !== 1'b0 || {mout2, mout1} !== 64'd0) begin
            bad++;
            $display("FAIL midreset_async got=%b/%h exp=0/0", finished, {mout2, mout1});
        end
        repeat (2) @(posedge clk);
        sbq.push_back(model(32'h0001_2345, 32'h000A_BCDE));
        @(negedge clk);
        reset = 1'b1;
        wait_done(n);
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL midreset_latency got=%0d exp=33", n);
        end
        e = pop_exp();
        total++;
        if ({mout2, mout1} !== e) begin
            bad++;
            $display("FAIL midreset_product got=%h exp=%h", {mout2, mout1}, e);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = $urandom;
            if (x == a) x = x ^ 32'd1;
            @(negedge clk);
            a = x;
            b = y;
            sbq.push_back(model(x, y));
            wait_done(n);
            total++;
            if (n !== 33) begin
                bad++;
                $display("FAIL b2b%0d_latency got=%0d exp=33", i, n);
            end
            e = pop_exp();
            total++;
            if ({mout2, mout1} !== e) begin
                bad++;
                $display("FAIL b2b%0d %h*%h got=%h exp=%h", i, x, y, {mout2, mout1}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_change();
        test_corners();
        test_busy_ignore();
        test_midreset();
        test_back_to_back();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
